// File: rtl/aes_pkg.sv
// Shared AES decryption definitions: FSM encoding, InvShiftRows byte mapping
// and the FIPS-197 inverse S-box constant table.
package aes_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SUB  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Row i of the table holds inverse S-box entries 16*i .. 16*i+15, entry 0 in the MSBs.
   localparam logic [2047:0] INV_SBOX_TABLE = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };

   // Output byte k = 4*col + row takes input column (col - row) mod 4, same row.
   function automatic logic [3:0] inv_shift_src(input logic [3:0] k);
      logic [1:0] row;
      logic [1:0] col;
      row = k[1:0];
      col = k[3:2];
      return {2'(col - row), row};
   endfunction

   function automatic logic [7:0] inv_sbox_lookup(input logic [7:0] b);
      return INV_SBOX_TABLE[11'd2047 - {b, 3'b000} -: 8];
   endfunction

   function automatic logic [7:0] get_byte(input logic [127:0] s, input logic [3:0] k);
      return s[7'd127 - {k, 3'b000} -: 8];
   endfunction

endpackage

// File: rtl/inv_sbox.sv
// Combinational FIPS-197 inverse S-box; shared with the decryption datapath.
module inv_sbox
   import aes_pkg::*;
(
   input  logic [7:0] i_byte,
   output logic [7:0] o_byte
);

   assign o_byte = inv_sbox_lookup(i_byte);

endmodule

// File: rtl/inv_shift_sub_engine.sv
// InvSubBytes(InvShiftRows(state)) engine processing BYTES_PER_CYCLE bytes per cycle
// with valid/ready handshakes on both sides.
module inv_shift_sub_engine
   import aes_pkg::*;
#(
   parameter int BYTES_PER_CYCLE = 1
)(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_state,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state,
   output logic         busy
);

   localparam int NUM_GRP = 16 / BYTES_PER_CYCLE;
   localparam int CNT_W   = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1;

   state_t           r_state;
   state_t           w_state_next;
   logic [CNT_W-1:0] r_cnt;
   logic [127:0]     r_src;
   logic [127:0]     r_out;
   logic [127:0]     w_out_next;
   logic             w_last;

   logic [3:0] w_dst_idx [BYTES_PER_CYCLE];
   logic [7:0] w_sb_in   [BYTES_PER_CYCLE];
   logic [7:0] w_sb_out  [BYTES_PER_CYCLE];

   genvar gi;
   generate
      for (gi = 0; gi < BYTES_PER_CYCLE; gi++) begin : g_lane
         assign w_dst_idx[gi] = 4'(int'(r_cnt) * BYTES_PER_CYCLE + gi);
         assign w_sb_in[gi]   = get_byte(r_src, inv_shift_src(w_dst_idx[gi]));
         inv_sbox u_inv_sbox (
            .i_byte (w_sb_in[gi]),
            .o_byte (w_sb_out[gi])
         );
      end
   endgenerate

   always_comb begin
      w_out_next = r_out;
      for (int i = 0; i < BYTES_PER_CYCLE; i++) begin
         w_out_next[7'd127 - {w_dst_idx[i], 3'b000} -: 8] = w_sb_out[i];
      end
   end

   assign w_last = (r_cnt == CNT_W'(NUM_GRP - 1));

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (in_valid)  w_state_next = ST_SUB;
         ST_SUB:  if (w_last)    w_state_next = ST_DONE;
         ST_DONE: if (out_ready) w_state_next = ST_IDLE;
         default:                w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_src   <= '0;
         r_out   <= '0;
      end else begin
         r_state <= w_state_next;
         if (r_state == ST_IDLE && in_valid) begin
            r_src <= in_state;
            r_cnt <= '0;
         end
         // out_state only changes while groups are being written.
         if (r_state == ST_SUB) begin
            r_out <= w_out_next;
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign in_ready  = (r_state == ST_IDLE);
   assign busy      = (r_state != ST_IDLE);
   assign out_valid = (r_state == ST_DONE);
   assign out_state = r_out;

endmodule

// File: tb/tb_inv_shift_sub_engine.sv
// Directed and random bench for inv_shift_sub_engine at 1, 4 and 16 bytes per cycle,
// checked against a reference built from GF(2^8) arithmetic.
module tb_inv_shift_sub_engine;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [127:0] in_state = '0;

   logic         ir1, ov1, by1, ir4, ov4, by4, ir16, ov16, by16;
   logic [127:0] os1, os4, os16;

   int checks = 0;
   int failures = 0;
   logic [7:0] isb [256];

   always #5 clk = ~clk;

   inv_shift_sub_engine #(.BYTES_PER_CYCLE(1)) u_b1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1), .in_state(in_state),
      .out_valid(ov1), .out_ready(out_ready), .out_state(os1), .busy(by1));
   inv_shift_sub_engine #(.BYTES_PER_CYCLE(4)) u_b4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir4), .in_state(in_state),
      .out_valid(ov4), .out_ready(out_ready), .out_state(os4), .busy(by4));
   inv_shift_sub_engine #(.BYTES_PER_CYCLE(16)) u_b16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir16), .in_state(in_state),
      .out_valid(ov16), .out_ready(out_ready), .out_state(os16), .busy(by16));

   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, p;
      a = a_in; b = b_in; p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
      return (v << n) | (v >> (8 - n));
   endfunction

   // Forward S-box = affine(GF inverse); its inverse is tabulated here.
   task automatic build_isb();
      logic [7:0] inv, s;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
         isb[s] = 8'(x);
      end
   endtask

   function automatic logic [127:0] model(input logic [127:0] s);
      logic [127:0] r;
      int src;
      r = '0;
      for (int col = 0; col < 4; col++)
         for (int row = 0; row < 4; row++) begin
            src = 4 * ((col - row + 4) % 4) + row;
            r[127 - 8*(4*col + row) -: 8] = isb[s[127 - 8*src -: 8]];
         end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_op(input logic [127:0] st, input logic rdy, output int l1, output int l4, output int l16);
      int edges;
      @(negedge clk);
      in_state = st; in_valid = 1'b1; out_ready = rdy;
      @(posedge clk); #1;
      in_valid = 1'b0;
      edges = 0; l1 = -1; l4 = -1; l16 = -1;
      while (edges < 40 && (l1 < 0 || l4 < 0 || l16 < 0)) begin
         @(posedge clk); #1;
         edges++;
         if (ov1 && l1 < 0) l1 = edges;
         if (ov4 && l4 < 0) l4 = edges;
         if (ov16 && l16 < 0) l16 = edges;
      end
   endtask

   task automatic release_all();
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1;
      chk("rel_in_ready", {ir1, ir4, ir16}, 3'b111);
      chk("rel_out_valid", {ov1, ov4, ov16}, 3'b000);
      out_ready = 1'b0;
   endtask

   task automatic check_all(input string tag, input logic [127:0] exp, input int l1, input int l4, input int l16);
      chk({tag, "_os1"}, os1, exp);
      chk({tag, "_os4"}, os4, exp);
      chk({tag, "_os16"}, os16, exp);
      chk({tag, "_lat1"}, 128'(l1), 128'd16);
      chk({tag, "_lat4"}, 128'(l4), 128'd4);
      chk({tag, "_lat16"}, 128'(l16), 128'd1);
   endtask

   initial begin
      logic [127:0] st, hold, rnd;
      int l1, l4, l16, edges;

      build_isb();
      #2;
      chk("rst_in_ready", {ir1, ir4, ir16}, 3'b111);
      chk("rst_busy", {by1, by4, by16}, 3'b000);
      chk("rst_out_valid", {ov1, ov4, ov16}, 3'b000);
      chk("rst_out_state", os1 | os4 | os16, 128'h0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_in_ready", {ir1, ir4, ir16, by1, by4, by16}, 6'b111000);

      // All 0x63 inverts to all zero.
      do_op({16{8'h63}}, 1'b0, l1, l4, l16);
      check_all("all63", 128'h0, l1, l4, l16);
      release_all();

      // A single changed byte in row 1 must land one column to the right.
      st = 128'h637c6363_63636363_63636363_63636363;
      do_op(st, 1'b0, l1, l4, l16);
      check_all("row1", 128'h00000000_00010000_00000000_00000000, l1, l4, l16);
      chk("row1_model", os1, model(st));

      // Backpressure with ignored input pulses.
      hold = os1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         in_valid = 1'b1; in_state = {$urandom, $urandom, $urandom, $urandom};
         @(posedge clk); #1;
         in_valid = 1'b0;
         chk("bp_out_valid", {ov1, ov4, ov16}, 3'b111);
         chk("bp_in_ready", {ir1, ir4, ir16}, 3'b000);
         chk("bp_out_state", os1, hold);
      end
      release_all();

      // Back-to-back with out_ready held high.
      do_op({16{8'h00}}, 1'b1, l1, l4, l16);
      check_all("all00", {16{8'h52}}, l1, l4, l16);
      @(posedge clk); #1;
      chk("b2b_in_ready", {ir1, ov1}, 2'b10);
      do_op({16{8'h16}}, 1'b1, l1, l4, l16);
      check_all("all16", {16{8'hff}}, l1, l4, l16);
      @(posedge clk); #1;
      out_ready = 1'b0;

      for (int t = 0; t < 8; t++) begin
         rnd = {$urandom, $urandom, $urandom, $urandom};
         do_op(rnd, 1'b0, l1, l4, l16);
         check_all("rand", model(rnd), l1, l4, l16);
         release_all();
      end

      // Reset in the middle of the byte-serial operation.
      @(negedge clk);
      in_state = {16{8'h52}}; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      edges = 0;
      repeat (7) begin @(posedge clk); edges++; end
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", {ov1, ov4, ov16}, 3'b000);
      chk("midrst_out_state", os1 | os4 | os16, 128'h0);
      chk("midrst_in_ready", {ir1, ir4, ir16, by1}, 4'b1110);
      @(negedge clk); rst_n = 1'b1;
      do_op({16{8'h63}}, 1'b0, l1, l4, l16);
      check_all("after_rst", 128'h0, l1, l4, l16);
      release_all();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/inv_shift_sub_engine.md
INV_SHIFT_SUB_ENGINE -- requirements
Module: inv_shift_sub_engine

Interface
REQ-001 SHALL have parameter BYTES_PER_CYCLE, default 1, giving the state bytes substituted per cycle; legal values are 1, 2, 4, 8 and 16.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: in_state is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the engine accepts a new state.
REQ-006 SHALL have port in_state, input, 128 bits: AES state, column-major; byte index k = 4*col + row occupies bits [127-8k -: 8].
REQ-007 SHALL have port out_valid, output, 1 bit: out_state holds a finished result.
REQ-008 SHALL have port out_ready, input, 1 bit: the consumer accepts out_state.
REQ-009 SHALL have port out_state, output, 128 bits: InvSubBytes(InvShiftRows(in_state)), same byte layout as in_state.
REQ-010 SHALL have port busy, output, 1 bit: high whenever the FSM is not IDLE.

Function
REQ-011 SHALL compute out[row][col] = InvSbox(in[row][(col - row) mod 4]), using the FIPS-197 inverse S-box.
REQ-012 SHALL implement FSM states IDLE, SUB and DONE.
REQ-013 SHALL assert in_ready only in IDLE; in_ready SHALL depend on registered state only.
REQ-014 SHALL treat in_valid & in_ready at a rising edge as acceptance: capture in_state into a source register, clear the byte counter and enter SUB.
REQ-015 SHALL ignore in_valid outside IDLE.
REQ-016 SHALL, in each SUB cycle, write output byte indices cnt*BYTES_PER_CYCLE through cnt*BYTES_PER_CYCLE + BYTES_PER_CYCLE - 1 and then increment cnt.
REQ-017 SHALL use a counter of width clog2(16/BYTES_PER_CYCLE), minimum 1 bit.
REQ-018 SHALL enter DONE on the edge that writes the last byte group, so out_valid rises exactly 16/BYTES_PER_CYCLE edges after the accepting edge.
REQ-019 SHALL, in DONE, hold out_valid high and keep out_state stable until out_valid & out_ready is sampled at an edge; it then returns to IDLE.
REQ-020 SHALL, when out_ready is already high on entry to DONE, stay in DONE for exactly one cycle; in_ready SHALL be high on the following cycle.
REQ-021 SHALL have no combinational path from any input to any output.
REQ-022 SHALL keep out_state unchanged outside SUB, and SHALL not clear it on handshake.

Reset
REQ-023 SHALL, while rst_n is low, immediately force: FSM to IDLE, cnt to 0, source register to 0, out_state to 0, out_valid to 0.
REQ-024 SHALL drive in_ready to 1 and busy to 0 while in reset and in the first cycle after rst_n deasserts.
REQ-025 SHALL abandon any in-flight operation when reset asserts; no partial result SHALL ever be flagged valid.

Structure
REQ-026 SHALL take the FSM state encoding, the InvShiftRows source-index function (output byte index -> input byte index) and the 256-entry inverse S-box constant table from shared package aes_pkg.
REQ-027 SHALL instantiate BYTES_PER_CYCLE copies of a combinational sub-module inv_sbox (8-bit in, 8-bit out, full 256-entry inverse table); this sub-module is also reused by the later decryption datapath.

Verification
REQ-028 SHALL cover: in_state = 0x63 in all 16 bytes, BYTES_PER_CYCLE=1 -> out_state 0x00 in all bytes, out_valid rising exactly 16 edges after acceptance.
REQ-029 SHALL cover: in_state byte 1 = 0x7c, all other bytes 0x63 -> out_state byte 5 = 0x01, all other bytes 0x00 (checks the row-1 shift).
REQ-030 SHALL cover: in_state all 0x00, then all 0x16, back-to-back with out_ready held high -> results all 0x52 then all 0xff; second in_ready seen the cycle after the first result handshake.
REQ-031 SHALL cover backpressure: out_ready held low 5 cycles in DONE -> out_valid and out_state stable for all 5, in_ready low, and in_valid pulses during that time ignored.
REQ-032 SHALL cover reset mid-operation: rst_n low at cnt=7 -> out_valid=0, out_state=0 and in_ready=1 immediately; a fresh all-0x63 state then completes normally to all-0x00.
REQ-033 SHALL cover: BYTES_PER_CYCLE=4 and 16 with the REQ-029 stimulus -> the same result, with latency 4 and 1 edges respectively.
